// File: rtl/time_digit_pkg.sv
// -----------------------------------------------------------------------------
// time_digit_pkg
// Shared constants and FSM encoding for the sec/msec digit split and combine
// blocks. Both the digit divider and the digit combiner import this package.
// -----------------------------------------------------------------------------
package time_digit_pkg;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [6:0] SEC_MAX      = 7'd59;
  localparam logic [6:0] MSEC_MAX     = 7'd99;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_mac_x10.sv
// -----------------------------------------------------------------------------
// bcd_mac_x10
// Combinational multiply-by-ten-and-add for BCD packing:
//   mac_o = acc_i * 10 + digit_i, built as (acc << 3) + (acc << 1) + digit.
// Ports:
//   acc_i   [6:0]  running accumulator
//   digit_i [3:0]  BCD digit to add
//   mac_o   [6:0]  result; callers guarantee it stays <= 99
// -----------------------------------------------------------------------------
module bcd_mac_x10 (
  input  logic [6:0] acc_i,
  input  logic [3:0] digit_i,
  output logic [6:0] mac_o
);

  // Upper accumulator bits are shifted out of the 7-bit result; with a
  // validated accumulator (<= 9 whenever it is multiplied) nothing is lost.
  assign mac_o = {acc_i[3:0], 3'b000} + {acc_i[5:0], 1'b0} + {3'b000, digit_i};

endmodule

// File: rtl/digit_combiner_sec_msec.sv
// -----------------------------------------------------------------------------
// digit_combiner_sec_msec
// Packs four BCD display digits (sec tens/ones, msec tens/ones) into binary
// sec (0..59) and msec (0..99) values for the time counter preload. One shared
// x10 MAC is stepped four times per request (start/busy/done handshake).
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 request, sampled only in IDLE
//   i_sec_10/i_sec_1        BCD seconds digits
//   i_msec_10/i_msec_1      BCD msec digits
//   o_sec, o_msec           registered binary results, updated together
//   o_busy                  conversion in progress
//   o_done                  one-cycle pulse after results update
//   o_err                   one-cycle pulse when a request is rejected
//
// Build option: DIGIT_COMBINER_CLAMP_EN -- out-of-range digits are clamped
// (digit -> 9, sec tens -> SEC_TENS_MAX) and converted; o_err never fires.
// -----------------------------------------------------------------------------
module digit_combiner_sec_msec
  import time_digit_pkg::*;
#(
  parameter int         SEC_W        = 6,
  parameter int         MSEC_W       = 10,
  parameter logic [3:0] SEC_TENS_MAX = time_digit_pkg::SEC_TENS_MAX
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_sec_10,
  input  logic [3:0]        i_sec_1,
  input  logic [3:0]        i_msec_10,
  input  logic [3:0]        i_msec_1,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MSEC_W-1:0] o_msec,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  conv_state_t       state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [6:0]        acc_q, acc_d;
  logic [6:0]        sec_res_q, sec_res_d;
  logic [3:0]        sec10_q, sec10_d, sec1_q, sec1_d;
  logic [3:0]        msec10_q, msec10_d, msec1_q, msec1_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MSEC_W-1:0] msec_q, msec_d;
  logic              err_q, err_d;

  // Request digits after optional clamping, plus the acceptance decision.
  logic [3:0] sec10_in, sec1_in, msec10_in, msec1_in;
  logic       req_ok;

`ifdef DIGIT_COMBINER_CLAMP_EN
  always_comb begin
    sec10_in  = (i_sec_10  > SEC_TENS_MAX) ? SEC_TENS_MAX : i_sec_10;
    sec1_in   = (i_sec_1   > DIGIT_MAX)    ? DIGIT_MAX    : i_sec_1;
    msec10_in = (i_msec_10 > DIGIT_MAX)    ? DIGIT_MAX    : i_msec_10;
    msec1_in  = (i_msec_1  > DIGIT_MAX)    ? DIGIT_MAX    : i_msec_1;
    req_ok    = 1'b1;
  end
`else
  always_comb begin
    sec10_in  = i_sec_10;
    sec1_in   = i_sec_1;
    msec10_in = i_msec_10;
    msec1_in  = i_msec_1;
    req_ok    = (i_sec_10 <= SEC_TENS_MAX) && (i_sec_10 <= DIGIT_MAX) &&
                (i_sec_1 <= DIGIT_MAX) && (i_msec_10 <= DIGIT_MAX) &&
                (i_msec_1 <= DIGIT_MAX);
  end
`endif

  // Shared MAC. Even steps start a new number, so the accumulator input is
  // forced to zero there instead of spending an extra cycle clearing it.
  logic [6:0] mac_acc, mac_out;
  logic [3:0] mac_digit;

  always_comb begin
    mac_acc   = step_q[0] ? acc_q : 7'd0;
    mac_digit = msec1_q;
    case (step_q)
      2'd0:    mac_digit = sec10_q;
      2'd1:    mac_digit = sec1_q;
      2'd2:    mac_digit = msec10_q;
      default: mac_digit = msec1_q;
    endcase
  end

  bcd_mac_x10 u_mac (
    .acc_i   (mac_acc),
    .digit_i (mac_digit),
    .mac_o   (mac_out)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    acc_d     = acc_q;
    sec_res_d = sec_res_q;
    sec10_d   = sec10_q;
    sec1_d    = sec1_q;
    msec10_d  = msec10_q;
    msec1_d   = msec1_q;
    sec_d     = sec_q;
    msec_d    = msec_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sec10_d  = sec10_in;
          sec1_d   = sec1_in;
          msec10_d = msec10_in;
          msec1_d  = msec1_in;
          if (req_ok) begin
            state_d = ST_CONV;
            step_d  = 2'd0;
            acc_d   = 7'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CONV: begin
        step_d = step_q + 2'd1;
        case (step_q)
          2'd0: acc_d = mac_out;
          2'd1: sec_res_d = mac_out;
          2'd2: acc_d = mac_out;
          default: begin
            // Both outputs load on the same edge so the counter never sees
            // a half-updated time.
            sec_d   = SEC_W'(sec_res_q);
            msec_d  = MSEC_W'(mac_out);
            state_d = ST_DONE;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= 2'd0;
      acc_q     <= 7'd0;
      sec_res_q <= 7'd0;
      sec10_q   <= 4'd0;
      sec1_q    <= 4'd0;
      msec10_q  <= 4'd0;
      msec1_q   <= 4'd0;
      sec_q     <= '0;
      msec_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      sec_res_q <= sec_res_d;
      sec10_q   <= sec10_d;
      sec1_q    <= sec1_d;
      msec10_q  <= msec10_d;
      msec1_q   <= msec1_d;
      sec_q     <= sec_d;
      msec_q    <= msec_d;
      err_q     <= err_d;
    end
  end

  assign o_sec  = sec_q;
  assign o_msec = msec_q;
  assign o_busy = (state_q == ST_CONV);
  assign o_done = (state_q == ST_DONE);
  assign o_err  = err_q;

endmodule

// File: tb/tb_digit_combiner_sec_msec.sv
module tb_digit_combiner_sec_msec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] s10 = 4'd0, s1 = 4'd0, m10 = 4'd0, m1 = 4'd0;
  logic [5:0] o_sec;
  logic [9:0] o_msec;
  logic       busy, done, err;

  digit_combiner_sec_msec dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_sec_10  (s10),
    .i_sec_1   (s1),
    .i_msec_10 (m10),
    .i_msec_1  (m1),
    .o_sec     (o_sec),
    .o_msec    (o_msec),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int msec;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   done_cnt  = 0;
  int   last_sec  = 0;
  int   last_msec = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference: plain decimal arithmetic on the requested digits.
  function automatic bit model(input int a, input int b, input int c, input int d,
                               output int es, output int em);
`ifdef DIGIT_COMBINER_CLAMP_EN
    if (a > 5) a = 5;
    if (b > 9) b = 9;
    if (c > 9) c = 9;
    if (d > 9) d = 9;
`else
    es = 0;
    em = 0;
    if (a > 5 || b > 9 || c > 9 || d > 9) return 1'b0;
`endif
    es = a * 10 + b;
    em = c * 10 + d;
    return 1'b1;
  endfunction

  // Scoreboard consumer: every o_done pops one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("o_sec", int'(o_sec), e.sec);
        check_val("o_msec", int'(o_msec), e.msec);
        last_sec  = e.sec;
        last_msec = e.msec;
        $display("[TB] done: sec=%0d msec=%0d (exp %0d/%0d)", o_sec, o_msec, e.sec, e.msec);
      end
      if (err === 1'b1) check_val("done_err_overlap", 1, 0);
    end
  end

  task automatic drive_digits(input int a, input int b, input int c, input int d);
    s10 = a[3:0];
    s1  = b[3:0];
    m10 = c[3:0];
    m1  = d[3:0];
  endtask

  // Wait (bounded) at posedge+1 until o_done; returns cycles taken and busy cycles.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic request(input int a, input int b, input int c, input int d);
    int es, em, cyc, bcnt, d0;
    bit ok;
    ok = model(a, b, c, d, es, em);
    @(negedge clk);
    drive_digits(a, b, c, d);
    start = 1'b1;
    if (ok) sb.push_back('{es, em});
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    $display("[TB] request %0d,%0d,%0d,%0d -> %s", a, b, c, d, ok ? "convert" : "reject");
    if (ok) begin
      check_val("busy_after_start", int'(busy), 1);
      check_val("err_on_valid", int'(err), 0);
      wait_done(cyc, bcnt);
      check_val("latency", cyc, 4);
      check_val("busy_cycles", bcnt, 4);
      @(posedge clk);
      #1;
      check_val("done_width", int'(done), 0);
      check_val("busy_after_done", int'(busy), 0);
      check_val("done_count", done_cnt - d0, 1);
    end else begin
      check_val("err_pulse", int'(err), 1);
      check_val("busy_on_err", int'(busy), 0);
      @(posedge clk);
      #1;
      check_val("err_width", int'(err), 0);
      check_val("busy_after_err", int'(busy), 0);
      check_val("sec_held", int'(o_sec), last_sec);
      check_val("msec_held", int'(o_msec), last_msec);
      check_val("no_done_on_err", done_cnt - d0, 0);
    end
  endtask

  initial begin : main
    int cyc, bcnt, d0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sec", int'(o_sec), 0);
    check_val("rst_msec", int'(o_msec), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    request(1, 2, 3, 4);
    request(5, 9, 9, 9);
    request(0, 0, 0, 0);
    request(1, 2, 3, 4);
    request(6, 9, 1, 1);      // sec tens out of range
    request(1, 2, 3, 4'hA);   // msec ones not BCD
    request(3, 7, 5, 8);

    // Requests and digit changes while converting are ignored.
    @(negedge clk);
    drive_digits(4, 5, 6, 7);
    start = 1'b1;
    sb.push_back('{45, 67});
    d0 = done_cnt;
    $display("[TB] request 4,5,6,7 with start/digit noise during CONV");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_digits(5 - i, 9, 9 - i, i);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    wait_done(cyc, bcnt);
    check_val("noise_done_seen", int'(done), 1);
    repeat (8) @(posedge clk);
    #1;
    check_val("noise_single_done", done_cnt - d0, 1);
    check_val("noise_idle", int'(busy), 0);

    // Reset at step 2 aborts the conversion.
    @(negedge clk);
    drive_digits(2, 3, 4, 5);
    start = 1'b1;
    sb.push_back('{23, 45});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] reset asserted mid-conversion");
    check_val("abort_sec", int'(o_sec), 0);
    check_val("abort_msec", int'(o_msec), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_err", int'(err), 0);
    sb.delete();
    d0 = done_cnt;
    last_sec  = 0;
    last_msec = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_val("abort_no_done", done_cnt - d0, 0);

    request(4, 7, 8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
